// File: rtl/tl_d_burst_router_if.sv
// D-channel bundle between a slave-side response source and the burst router.
// Modport slave is the router's view; modport master is the environment's view.
interface tl_d_burst_router_if #(
  parameter int MASTER_NUM = 4,
  parameter int SOURCE_W   = 8,
  parameter int SIZE_W     = 4,
  parameter int DATA_W     = 64
);
  logic                  inp_valid_i;
  logic                  inp_ready_o;
  logic [SOURCE_W-1:0]   inp_source_i;
  logic [2:0]            inp_opcode_i;
  logic [SIZE_W-1:0]     inp_size_i;
  logic [DATA_W-1:0]     inp_data_i;
  logic [MASTER_NUM-1:0] oup_valid_o;
  logic [MASTER_NUM-1:0] oup_ready_i;
  logic [SOURCE_W-1:0]   oup_source_o;
  logic [2:0]            oup_opcode_o;
  logic [SIZE_W-1:0]     oup_size_o;
  logic [DATA_W-1:0]     oup_data_o;
  logic                  busy_o;
  logic                  dbg_state_o;

  // Handshake: a beat moves on a side when its valid and the matching ready are
  // both high at the rising clock edge; valid and payload hold until then.
  modport slave (
    input  inp_valid_i, inp_source_i, inp_opcode_i, inp_size_i, inp_data_i, oup_ready_i,
    output inp_ready_o, oup_valid_o, oup_source_o, oup_opcode_o, oup_size_o, oup_data_o,
    output busy_o, dbg_state_o
  );

  modport master (
    output inp_valid_i, inp_source_i, inp_opcode_i, inp_size_i, inp_data_i, oup_ready_i,
    input  inp_ready_o, oup_valid_o, oup_source_o, oup_opcode_o, oup_size_o, oup_data_o,
    input  busy_o, dbg_state_o
  );
endinterface

// File: rtl/tl_d_burst_router.sv
// Registered burst-aware TileLink D-channel router: one slave D channel to MASTER_NUM masters.
// Optional TL_D_ROUTER_ERR_EN: drop out-of-range responses and pulse err_o instead of clamping.
module tl_d_burst_router #(
  parameter int MASTER_NUM = 4,
  parameter int SOURCE_LSB = 4,
  parameter int SOURCE_MSB = 6,
  parameter int SOURCE_W   = 8,
  parameter int SIZE_W     = 4,
  parameter int DATA_W     = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tl_d_burst_router_if.slave  bus
`ifdef TL_D_ROUTER_ERR_EN
  ,
  output logic                err_o
`endif
);
  localparam int ROUTE_W   = SOURCE_MSB - SOURCE_LSB;
  localparam int BEAT_LOG2 = $clog2(DATA_W / 8);
  localparam int IDX_W     = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  typedef logic [SOURCE_W-1:0] source_t;
  typedef enum logic { S_IDLE = 1'b0, S_BURST = 1'b1 } state_t;

  state_t             r_state, w_state_nxt;
  logic [SIZE_W-1:0]  r_remaining, w_remaining_nxt;
  logic [IDX_W-1:0]   r_burst_route, w_burst_route_nxt;
  logic [IDX_W-1:0]   r_out_route;
  logic [IDX_W-1:0]   w_route_sel, w_route_act;
  logic [ROUTE_W-1:0] w_route_raw;
  logic [SIZE_W-1:0]  w_first_rem;
  logic               w_oor, w_multi, w_accept, w_drop, w_load, w_drain, w_base_ready;
  logic               r_full;
  source_t            r_source;
  logic [2:0]         r_opcode;
  logic [SIZE_W-1:0]  r_size;
  logic [DATA_W-1:0]  r_data;

  assign w_route_raw = bus.inp_source_i[SOURCE_MSB-1:SOURCE_LSB];
  assign w_oor       = 32'(w_route_raw) >= MASTER_NUM;
  assign w_route_sel = w_oor ? IDX_W'(MASTER_NUM - 1) : IDX_W'(w_route_raw);
  assign w_route_act = (r_state == S_BURST) ? r_burst_route : w_route_sel;

  // Only data-carrying opcodes span multiple beats; the count is held in SIZE_W bits.
  assign w_multi     = ((bus.inp_opcode_i == 3'd1) || (bus.inp_opcode_i == 3'd5)) &&
                       (32'(bus.inp_size_i) > BEAT_LOG2);
  assign w_first_rem = w_multi ? SIZE_W'((32'd1 << (32'(bus.inp_size_i) - BEAT_LOG2)) - 32'd1)
                               : '0;

  assign w_base_ready = !r_full || bus.oup_ready_i[r_out_route];
  assign w_accept     = bus.inp_valid_i && bus.inp_ready_o;
  assign w_load       = w_accept && !w_drop;
  assign w_drain      = r_full && bus.oup_ready_i[r_out_route];

`ifdef TL_D_ROUTER_ERR_EN
  logic r_drop, w_drop_nxt, r_err;

  // A dropped response is swallowed regardless of the output register state.
  assign w_drop          = (r_state == S_BURST) ? r_drop : w_oor;
  assign bus.inp_ready_o = w_base_ready || w_drop;
  assign err_o           = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_drop <= w_drop_nxt;
      r_err  <= w_accept && (r_state == S_IDLE) && w_oor;
    end
  end
`else
  assign w_drop          = 1'b0;
  assign bus.inp_ready_o = w_base_ready;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_remaining   <= '0;
      r_burst_route <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_remaining   <= w_remaining_nxt;
      r_burst_route <= w_burst_route_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_remaining_nxt   = r_remaining;
    w_burst_route_nxt = r_burst_route;
`ifdef TL_D_ROUTER_ERR_EN
    w_drop_nxt        = r_drop;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_remaining_nxt   = w_first_rem;
          w_burst_route_nxt = w_route_sel;
`ifdef TL_D_ROUTER_ERR_EN
          w_drop_nxt        = w_oor;
`endif
          if (w_first_rem != '0) w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (w_accept) begin
          if (r_remaining <= SIZE_W'(1)) begin
            w_remaining_nxt = '0;
            w_state_nxt     = S_IDLE;
`ifdef TL_D_ROUTER_ERR_EN
            w_drop_nxt      = 1'b0;
`endif
          end else begin
            w_remaining_nxt = r_remaining - SIZE_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Load and drain in the same cycle keeps the entry full, giving full throughput.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full      <= 1'b0;
      r_out_route <= '0;
      r_source    <= '0;
      r_opcode    <= '0;
      r_size      <= '0;
      r_data      <= '0;
    end else begin
      r_full <= w_load || (r_full && !w_drain);
      if (w_load) begin
        r_out_route <= w_route_act;
        r_source    <= bus.inp_source_i;
        r_opcode    <= bus.inp_opcode_i;
        r_size      <= bus.inp_size_i;
        r_data      <= bus.inp_data_i;
      end
    end
  end

  assign bus.oup_valid_o  = r_full ? (MASTER_NUM'(1) << r_out_route) : '0;
  assign bus.oup_source_o = r_source;
  assign bus.oup_opcode_o = r_opcode;
  assign bus.oup_size_o   = r_size;
  assign bus.oup_data_o   = r_data;
  assign bus.busy_o       = (r_state == S_BURST) || r_full;
  assign bus.dbg_state_o  = r_state;
endmodule

// File: tb/tb_tl_d_burst_router.sv
// Directed bench for tl_d_burst_router: a 4-master instance for routing, bursts,
// backpressure and reset, plus a 3-master instance for the out-of-range route.
module tb_tl_d_burst_router;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  tl_d_burst_router_if #(.MASTER_NUM(4), .SOURCE_W(8), .SIZE_W(4), .DATA_W(64)) b4 ();
  tl_d_burst_router_if #(.MASTER_NUM(3), .SOURCE_W(8), .SIZE_W(4), .DATA_W(64)) b3 ();

`ifdef TL_D_ROUTER_ERR_EN
  logic err4, err3;
`endif

  tl_d_burst_router #(
    .MASTER_NUM(4), .SOURCE_LSB(4), .SOURCE_MSB(6), .SOURCE_W(8), .SIZE_W(4), .DATA_W(64)
  ) u_dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b4)
`ifdef TL_D_ROUTER_ERR_EN
    ,
    .err_o  (err4)
`endif
  );

  tl_d_burst_router #(
    .MASTER_NUM(3), .SOURCE_LSB(4), .SOURCE_MSB(6), .SOURCE_W(8), .SIZE_W(4), .DATA_W(64)
  ) u_dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b3)
`ifdef TL_D_ROUTER_ERR_EN
    ,
    .err_o  (err3)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks
  task automatic drive4(input logic v, input logic [7:0] src, input logic [2:0] op,
                        input logic [3:0] sz, input logic [63:0] d);
    b4.inp_valid_i  = v;
    b4.inp_source_i = src;
    b4.inp_opcode_i = op;
    b4.inp_size_i   = sz;
    b4.inp_data_i   = d;
  endtask

  task automatic drive3(input logic v, input logic [7:0] src, input logic [2:0] op,
                        input logic [3:0] sz, input logic [63:0] d);
    b3.inp_valid_i  = v;
    b3.inp_source_i = src;
    b3.inp_opcode_i = op;
    b3.inp_size_i   = sz;
    b3.inp_data_i   = d;
  endtask

  initial begin
    logic [7:0] b2b_src [3];
    logic [3:0] b2b_vld [3];
    b2b_src = '{8'h00, 8'h30, 8'h05};
    b2b_vld = '{4'b0001, 4'b1000, 4'b0001};

    rst_n = 1'b0;
    drive4(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    drive3(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    b4.oup_ready_i = 4'b0000;
    b3.oup_ready_i = 3'b000;

    // Reset state
    #3;
    chk("rst_valid4", 64'(b4.oup_valid_o), 64'h0);
    chk("rst_busy4", 64'(b4.busy_o), 64'h0);
    chk("rst_ready4", 64'(b4.inp_ready_o), 64'h1);
    chk("rst_state4", 64'(b4.dbg_state_o), 64'h0);
    chk("rst_data4", b4.oup_data_o, 64'h0);
    chk("rst_valid3", 64'(b3.oup_valid_o), 64'h0);
`ifdef TL_D_ROUTER_ERR_EN
    chk("rst_err4", 64'(err4), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single AccessAck to master 2
    b4.oup_ready_i = 4'b0100;
    drive4(1'b1, 8'h20, 3'd0, 4'd3, 64'hA1);
    chk("single_inready", 64'(b4.inp_ready_o), 64'h1);
    tick();
    drive4(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    chk("single_valid", 64'(b4.oup_valid_o), 64'h4);
    chk("single_data", b4.oup_data_o, 64'hA1);
    chk("single_source", 64'(b4.oup_source_o), 64'h20);
    chk("single_busy", 64'(b4.busy_o), 64'h1);
    tick();
    chk("single_drained", 64'(b4.oup_valid_o), 64'h0);
    chk("single_idle_busy", 64'(b4.busy_o), 64'h0);

    // 4-beat AccessAckData; later beats carry a different route field
    b4.oup_ready_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, (i == 0) ? 8'h10 : 8'h30, 3'd1, 4'd5, 64'hB0 + 64'(i));
      tick();
      chk("burst_valid", 64'(b4.oup_valid_o), 64'h2);
      chk("burst_data", b4.oup_data_o, 64'hB0 + 64'(i));
      chk("burst_state", 64'(b4.dbg_state_o), (i < 3) ? 64'h1 : 64'h0);
      chk("burst_busy", 64'(b4.busy_o), 64'h1);
    end
    drive4(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    tick();
    chk("burst_end_valid", 64'(b4.oup_valid_o), 64'h0);
    chk("burst_end_busy", 64'(b4.busy_o), 64'h0);

    // Backpressure on master 1
    b4.oup_ready_i = 4'b1101;
    drive4(1'b1, 8'h10, 3'd0, 4'd0, 64'hC0);
    chk("bp_ready_empty", 64'(b4.inp_ready_o), 64'h1);
    tick();
    drive4(1'b1, 8'h10, 3'd0, 4'd0, 64'hC1);
    chk("bp_ready_full", 64'(b4.inp_ready_o), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ready", 64'(b4.inp_ready_o), 64'h0);
      chk("bp_hold_valid", 64'(b4.oup_valid_o), 64'h2);
      chk("bp_hold_data", b4.oup_data_o, 64'hC0);
    end
    b4.oup_ready_i = 4'b1111;
    #1;
    chk("bp_ready_back", 64'(b4.inp_ready_o), 64'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("bp_stream_valid", 64'(b4.oup_valid_o), 64'h2);
      chk("bp_stream_data", b4.oup_data_o, 64'hC0 + 64'(i));
      drive4(1'b1, 8'h10, 3'd0, 4'd0, 64'hC1 + 64'(i));
    end
    drive4(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    tick();
    chk("bp_end_valid", 64'(b4.oup_valid_o), 64'h0);

    // Back-to-back single beats to masters 0, 3, 0
    for (int i = 0; i < 3; i++) begin
      drive4(1'b1, b2b_src[i], 3'd0, 4'd2, 64'hD0 + 64'(i));
      tick();
      chk("b2b_valid", 64'(b4.oup_valid_o), 64'(b2b_vld[i]));
      chk("b2b_data", b4.oup_data_o, 64'hD0 + 64'(i));
    end
    drive4(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    tick();
    chk("b2b_end_valid", 64'(b4.oup_valid_o), 64'h0);

    // Out-of-range route on the 3-master instance, 2-beat GrantData
    b3.oup_ready_i = 3'b111;
    drive3(1'b1, 8'h30, 3'd5, 4'd4, 64'hE0);
    chk("oor_ready1", 64'(b3.inp_ready_o), 64'h1);
    tick();
`ifdef TL_D_ROUTER_ERR_EN
    chk("oor_drop_valid1", 64'(b3.oup_valid_o), 64'h0);
    chk("oor_err_pulse", 64'(err3), 64'h1);
    chk("oor_state1", 64'(b3.dbg_state_o), 64'h1);
    drive3(1'b1, 8'h00, 3'd5, 4'd4, 64'hE1);
    chk("oor_ready2", 64'(b3.inp_ready_o), 64'h1);
    tick();
    chk("oor_drop_valid2", 64'(b3.oup_valid_o), 64'h0);
    chk("oor_err_low", 64'(err3), 64'h0);
    chk("oor_state2", 64'(b3.dbg_state_o), 64'h0);
    drive3(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    tick();
    chk("oor_end_valid", 64'(b3.oup_valid_o), 64'h0);
    chk("oor_end_err", 64'(err3), 64'h0);
`else
    chk("oor_clamp_valid1", 64'(b3.oup_valid_o), 64'h4);
    chk("oor_clamp_data1", b3.oup_data_o, 64'hE0);
    chk("oor_state1", 64'(b3.dbg_state_o), 64'h1);
    drive3(1'b1, 8'h00, 3'd5, 4'd4, 64'hE1);
    tick();
    chk("oor_clamp_valid2", 64'(b3.oup_valid_o), 64'h4);
    chk("oor_clamp_data2", b3.oup_data_o, 64'hE1);
    chk("oor_state2", 64'(b3.dbg_state_o), 64'h0);
    drive3(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    tick();
    chk("oor_end_valid", 64'(b3.oup_valid_o), 64'h0);
`endif

    // Reset in the middle of a 4-beat burst
    b4.oup_ready_i = 4'b1111;
    drive4(1'b1, 8'h10, 3'd1, 4'd5, 64'h90);
    tick();
    drive4(1'b1, 8'h10, 3'd1, 4'd5, 64'h91);
    tick();
    chk("mid_pre_state", 64'(b4.dbg_state_o), 64'h1);
    chk("mid_pre_data", b4.oup_data_o, 64'h91);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(b4.oup_valid_o), 64'h0);
    chk("mid_rst_busy", 64'(b4.busy_o), 64'h0);
    chk("mid_rst_state", 64'(b4.dbg_state_o), 64'h0);
    chk("mid_rst_data", b4.oup_data_o, 64'h0);
    drive4(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    #1;
    rst_n = 1'b1;
    drive4(1'b1, 8'h30, 3'd0, 4'd3, 64'hF0);
    tick();
    chk("post_rst_valid", 64'(b4.oup_valid_o), 64'h8);
    chk("post_rst_data", b4.oup_data_o, 64'hF0);
    chk("post_rst_state", 64'(b4.dbg_state_o), 64'h0);
    drive4(1'b0, 8'h00, 3'd0, 4'd0, 64'h0);
    tick();
    chk("post_rst_end", 64'(b4.oup_valid_o), 64'h0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
